// File: rtl/req_rsp_responder.sv
// Register-file responder: one outstanding request, fixed RSP_LAT request-to-response latency.
// Optional macro REQ_RSP_RESPONDER_CNT_EN adds the 16-bit txn_cnt response counter port.
module req_rsp_responder #(
   parameter int                ADDR_W   = 4,
   parameter int                DATA_W   = 32,
   parameter int                NUM_REGS = 12,
   parameter int                RSP_LAT  = 2,
   parameter logic [DATA_W-1:0] ID_VAL   = 32'hA5A5_0001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
`ifdef REQ_RSP_RESPONDER_CNT_EN
   ,
   output logic [15:0]       txn_cnt
`endif
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // valid, once raised, stays high with stable payload until that transfer.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0]      LAT_M1     = 4'(RSP_LAT - 1);
   localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

   state_t            state_q;
   state_t            state_d;
   logic [3:0]        cnt_q;
   logic [3:0]        cnt_d;
   logic              live_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic [DATA_W-1:0] regs [1:NUM_REGS-1];

   logic              req_xfer;
   logic              rsp_xfer;
   logic              addr_ok;
   logic              req_err;
   logic [DATA_W-1:0] rd_val;

   assign req_ready = (state_q == IDLE) && live_q;
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   assign req_xfer = req_valid && req_ready;
   assign rsp_xfer = rsp_valid && rsp_ready;

   // Address 0 is the read-only ID register, so writing it is illegal.
   assign addr_ok = ({1'b0, req_addr} < NUM_REGS_W);
   assign req_err = !addr_ok || (req_write && (req_addr == '0));

   always_comb begin
      rd_val = '0;
      if (req_addr == '0) begin
         rd_val = ID_VAL;
      end
      for (int i = 1; i < NUM_REGS; i++) begin
         if (req_addr == ADDR_W'(i)) begin
            rd_val = regs[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_xfer) begin
               cnt_d   = LAT_M1;
               state_d = (RSP_LAT > 1) ? WAIT : RESP;
            end
         end
         WAIT: begin
            // The edge that brings the counter to 0 is the edge that enters RESP.
            if (cnt_q <= 4'd1) begin
               cnt_d   = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         live_q  <= 1'b1;
      end
   end

   // Response payload is fixed at request acceptance and held through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (req_xfer) begin
         err_q   <= req_err;
         rdata_q <= (req_err || req_write) ? '0 : rd_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (req_xfer && req_write && !req_err) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (req_addr == ADDR_W'(i)) begin
               regs[i] <= req_wdata;
            end
         end
      end
   end

`ifdef REQ_RSP_RESPONDER_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txn_cnt <= '0;
      end else if (rsp_xfer) begin
         txn_cnt <= txn_cnt + 16'd1;
      end
   end
`else
   logic unused_rsp_xfer;
   assign unused_rsp_xfer = rsp_xfer;
`endif

endmodule

// File: tb/tb_req_rsp_responder.sv
// Directed bench for req_rsp_responder with default parameters (optionally with
// REQ_RSP_RESPONDER_CNT_EN defined to cover txn_cnt).
module tb_req_rsp_responder;

   localparam logic [31:0] ID = 32'hA5A5_0001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [3:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef REQ_RSP_RESPONDER_CNT_EN
   logic [15:0] txn_cnt;
`endif

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   req_rsp_responder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
`ifdef REQ_RSP_RESPONDER_CNT_EN
      ,
      .txn_cnt   (txn_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish before 500000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic chk_cnt(input string tag);
`ifdef REQ_RSP_RESPONDER_CNT_EN
      chk(tag, 32'(txn_cnt), 32'(exp_cnt));
`endif
   endtask

   // Waits at negedges for rsp_valid; leaves the caller at the negedge where it was seen.
   task automatic wait_rsp(input string tag);
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(rsp_valid), 32'd1);
   endtask

   // One request; lat = edges from request transfer to response transfer.
   task automatic do_req(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
      int n;
      rd  = '0;
      er  = 1'b0;
      lat = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      rsp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) begin
            rd = rsp_rdata;
            er = rsp_err;
            @(posedge clk);
            exp_cnt++;
            #1;
            return;
         end
      end
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
   endtask

   task automatic xact(input string tag, input logic wr, input logic [3:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(wr, a, wd, rd, er, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd2);
      chk({tag, "_err"}, 32'(er), 32'(exp_err));
      chk({tag, "_rdata"}, rd, exp_rd);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 4'd0;
      req_wdata = 32'd0;
      rsp_ready = 1'b0;

      // reset state
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk_cnt("rst_txn_cnt");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rel_req_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rel_req_ready_high", 32'(req_ready), 32'd1);

      // write then read back
      xact("wr3", 1'b1, 4'd3, 32'hDEAD_BEEF, 32'd0, 1'b0);
      xact("rd3", 1'b0, 4'd3, 32'd0, 32'hDEAD_BEEF, 1'b0);

      // ID register
      xact("rd0", 1'b0, 4'd0, 32'd0, ID, 1'b0);
      xact("wr0", 1'b1, 4'd0, 32'd1, 32'd0, 1'b1);
      xact("rd0_again", 1'b0, 4'd0, 32'd0, ID, 1'b0);
      chk_cnt("cnt_after_5");

      // stalled response with a second request waiting behind it
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 4'd3;
      req_wdata = 32'd0;
      rsp_ready = 1'b0;
      chk("stall_acc_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_write = 1'b1;
      req_addr  = 4'd4;
      req_wdata = 32'h0000_0055;
      wait_rsp("stall_rsp_seen");
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rdata", rsp_rdata, 32'hDEAD_BEEF);
         chk("stall_err", 32'(rsp_err), 32'd0);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         chk_cnt("stall_cnt");
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      exp_cnt++;
      @(negedge clk);
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rsp_req_ready", 32'(req_ready), 32'd1);
      chk_cnt("post_rsp_cnt");
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("second_accepted", 32'(req_ready), 32'd0);
      wait_rsp("second_rsp_seen");
      chk("second_err", 32'(rsp_err), 32'd0);
      chk("second_rdata", rsp_rdata, 32'd0);
      @(posedge clk);
      exp_cnt++;
      #1;
      xact("rd4", 1'b0, 4'd4, 32'd0, 32'h0000_0055, 1'b0);

      // reset while a read response is stalled in RESP
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 4'd0;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp("resp_rst_seen");
      chk("resp_rst_pre_rdata", rsp_rdata, ID);
      rst_n = 1'b0;
      exp_cnt = 0;
      #1;
      chk("resp_rst_valid", 32'(rsp_valid), 32'd0);
      chk("resp_rst_rdata", rsp_rdata, 32'd0);
      chk("resp_rst_req_ready", 32'(req_ready), 32'd0);
      chk_cnt("resp_rst_cnt");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("resp_rst_ready_back", 32'(req_ready), 32'd1);

      // reset in WAIT after a committed write to addr 5
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 4'd5;
      req_wdata = 32'd7;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("wait_rst_valid", 32'(rsp_valid), 32'd0);
      chk("wait_rst_req_ready", 32'(req_ready), 32'd0);
      chk("wait_rst_rdata", rsp_rdata, 32'd0);
      chk("wait_rst_err", 32'(rsp_err), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("wait_rst_rel_low", 32'(req_ready), 32'd0);
      xact("rd5_after_rst", 1'b0, 4'd5, 32'd0, 32'd0, 1'b0);

      // illegal addresses, then every implemented register must still be 0
      xact("rd12", 1'b0, 4'd12, 32'd0, 32'd0, 1'b1);
      xact("wr15", 1'b1, 4'd15, 32'hFFFF_FFFF, 32'd0, 1'b1);
`ifdef REQ_RSP_RESPONDER_CNT_EN
      chk("cnt3", 32'(txn_cnt), 32'd3);
`endif
      xact("wr12", 1'b1, 4'd12, 32'h1234_5678, 32'd0, 1'b1);
      xact("rd15", 1'b0, 4'd15, 32'd0, 32'd0, 1'b1);
      for (int a = 1; a < 12; a++) begin
         xact("sweep_zero", 1'b0, 4'(a), 32'd0, 32'd0, 1'b0);
      end

      // edge registers 1 and 11 hold independent values
      xact("wr1", 1'b1, 4'd1, 32'h1111_1111, 32'd0, 1'b0);
      xact("wr11", 1'b1, 4'd11, 32'hBBBB_0011, 32'd0, 1'b0);
      xact("rd1", 1'b0, 4'd1, 32'd0, 32'h1111_1111, 1'b0);
      xact("rd10", 1'b0, 4'd10, 32'd0, 32'd0, 1'b0);
      xact("rd11", 1'b0, 4'd11, 32'd0, 32'hBBBB_0011, 1'b0);
      chk_cnt("cnt_final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/req_rsp_responder.md
REQ_RSP_RESPONDER -- requirements
Module: req_rsp_responder

Interface
REQ-001 Parameter ADDR_W, default 4, request address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter NUM_REGS, default 12, implemented register count; 2 <= NUM_REGS <= 2**ADDR_W.
REQ-004 Parameter RSP_LAT, default 2, request-to-response latency in cycles; legal range 1..15.
REQ-005 Parameter ID_VAL, default 32'hA5A5_0001, read-only value of register 0.
REQ-006 Port clk  input  1  single clock; all logic on the rising edge.
REQ-007 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 Port req_valid  input  1  request present.
REQ-009 Port req_ready  output  1  responder can accept a request.
REQ-010 Port req_write  input  1  1 = write, 0 = read.
REQ-011 Port req_addr  input  ADDR_W  register index.
REQ-012 Port req_wdata  input  DATA_W  write data.
REQ-013 Port rsp_valid  output  1  response present.
REQ-014 Port rsp_ready  input  1  initiator accepts the response.
REQ-015 Port rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-016 Port rsp_err  output  1  request was illegal.

Function
REQ-017 Request transfer occurs on a rising edge where req_valid and req_ready are both 1; response transfer occurs on an edge where rsp_valid and rsp_ready are both 1.
REQ-018 FSM states: IDLE, WAIT, RESP. Only one request is outstanding at a time.
REQ-019 IDLE: req_ready = 1, rsp_valid = 0. A request transfer goes to WAIT if RSP_LAT > 1, or to RESP if RSP_LAT = 1, and loads the latency counter with RSP_LAT-1.
REQ-020 WAIT: req_ready = 0. The counter decrements each cycle, and the FSM enters RESP when the counter reaches 0. rsp_valid rises exactly RSP_LAT edges after the request transfer edge.
REQ-021 RESP: rsp_valid = 1, and rsp_rdata and rsp_err are held stable until the response transfer, which returns the FSM to IDLE. rsp_valid is never dropped without a transfer.
REQ-022 Write side effects: the register updates on the request transfer edge. Read data is captured on the request transfer edge.
REQ-023 Error cases: req_addr >= NUM_REGS, or a write to address 0. Either sets rsp_err = 1 and rsp_rdata = 0, with no register change.
REQ-024 A read of address 0 returns ID_VAL. A read of addresses 1..NUM_REGS-1 returns the stored value.
REQ-025 req_valid while not in IDLE has no effect. The initiator holds the request because req_ready = 0.
REQ-026 rsp_ready = 1 outside RESP is ignored.
REQ-027 A response transfer and a new request do not complete in the same cycle. The next request is accepted at the earliest one cycle after the response transfer.

Reset
REQ-028 When rst_n = 0, the following take effect asynchronously:
- FSM goes to IDLE.
- req_ready = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Counter = 0.
- Registers 1..NUM_REGS-1 = 0.
REQ-029 req_ready rises on the first clock edge after rst_n deasserts.
REQ-030 Reset during WAIT or RESP discards the outstanding response. Any write already committed before reset is cleared by the register reset.

Configuration
REQ-031 Macro REQ_RSP_RESPONDER_CNT_EN. When defined:
- Adds output port txn_cnt, 16 bits, reset to 0.
- txn_cnt increments on every response transfer and wraps from 16'hFFFF to 0.
- Error responses are counted.
REQ-032 When REQ_RSP_RESPONDER_CNT_EN is undefined, port txn_cnt and its logic are absent; all other behaviour is identical.

Verification
REQ-033 Scenario: write addr 3 data 32'hDEAD_BEEF, then read addr 3 (default parameters, rsp_ready = 1). Required: rsp_valid 2 cycles after each request transfer, rsp_err = 0, and the read returns 32'hDEAD_BEEF.
REQ-034 Scenario: read addr 0. Required: rsp_rdata = 32'hA5A5_0001, rsp_err = 0. Then write addr 0 data 1. Required: rsp_err = 1, and a subsequent read of addr 0 still returns 32'hA5A5_0001.
REQ-035 Scenario: read addr 12 and write addr 15 with NUM_REGS = 12. Required: rsp_err = 1 and rsp_rdata = 0 for both; a read of every addr 1..11 afterwards returns 0.
REQ-036 Scenario: hold rsp_ready = 0 for 5 cycles in RESP while req_valid = 1. Required: rsp_valid and data stable, req_ready = 0, and the second request is accepted 1 cycle after the response transfer.
REQ-037 Scenario: assert rst_n = 0 in WAIT after a write to addr 5 with data 7. Required: outputs go to 0 immediately, and a read of addr 5 after reset returns 0.
REQ-038 Scenario: with REQ_RSP_RESPONDER_CNT_EN defined, complete 3 requests including 1 error. Required: txn_cnt = 3, and txn_cnt does not change while a response is stalled.
